alu_seq: RTL and testbench

- WIDTH-parametrised ALU for the pipelined MIPS-Lite EX stage.
- Keeps the existing single-cycle operation set (AND/OR/ADD/SUB/SLT) and produces the whole word, so it does not need one slice per bit.
- Adds multi-cycle unsigned multiply and divide with internal HI/LO registers, plus MFHI/MFLO reads.
- Uses a start/busy/done handshake so the hazard unit can stall the pipeline while a long operation runs.

---
 rtl/alu_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-parametrised EX-stage ALU with multi-cycle MULTU/DIVU and HI/LO registers
//
// Single-cycle ops (AND, OR, ADD, SUB, SLT, MFHI, MFLO, undefined codes) are
// registered at the accepting edge and flagged by a one-cycle done pulse.
// MULTU/DIVU latch their operands, hold busy for WIDTH cycles while iterating
// one bit per cycle, then commit HI/LO and pulse done.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request, sampled only while busy=0
//   Signal    4-bit operation code
//   dataA     operand A
//   dataB     operand B
//   dataOut   registered result
//   CarryOut  registered carry (ADD/SUB only)
//   Overflow  registered signed overflow (ADD/SUB only)
//   Zero      registered dataOut==0
//   busy      high while MULTU/DIVU is iterating
//   done      one-cycle pulse when the result is valid

module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Working {upper, lower} pair: partial product/multiplier or remainder/quotient.
    logic [WIDTH-1:0]   wh_q, wh_d;
    logic [WIDTH-1:0]   wl_q, wl_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   sum;
    logic               add_ovf;
    logic               sub_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_n;
    logic [WIDTH-1:0]   div_lo_n;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    always_comb begin
        // Shared adder: SUB and SLT use A + ~B + 1.
        is_sub  = (Signal == OP_SUB) || (Signal == OP_SLT);
        b_eff   = is_sub ? ~dataB : dataB;
        sum_ext = {1'b0, dataA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        sum     = sum_ext[WIDTH-1:0];
        add_ovf = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);
        sub_ovf = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (sum[WIDTH-1] != dataA[WIDTH-1]);

        // Shift-add multiply step: add multiplicand when multiplier LSB is set,
        // then shift the whole {upper, lower} pair right by one.
        mul_sum  = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], wl_q[WIDTH-1:1]};

        // Restoring divide step: shift next dividend bit into the remainder,
        // subtract the divisor if it fits. A zero divisor always "fits",
        // which yields quotient all-ones and remainder equal to the dividend.
        div_shift = {wh_q, wl_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_hi_n  = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        div_lo_n  = {wl_q[WIDTH-2:0], div_ge};

        step_hi = is_div_q ? div_hi_n : mul_hi_n;
        step_lo = is_div_q ? div_lo_n : mul_lo_n;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        opnd_d     = opnd_q;
        wh_d       = wh_q;
        wl_d       = wl_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        data_out_d = data_out_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((Signal == OP_MULTU) || (Signal == OP_DIVU)) begin
                        state_d  = RUN;
                        cnt_d    = CNT_W'(WIDTH);
                        busy_d   = 1'b1;
                        is_div_d = (Signal == OP_DIVU);
                        opnd_d   = (Signal == OP_DIVU) ? dataB : dataA;
                        wh_d     = '0;
                        wl_d     = (Signal == OP_DIVU) ? dataA : dataB;
                    end else begin
                        done_d  = 1'b1;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        case (Signal)
                            OP_AND:  data_out_d = dataA & dataB;
                            OP_OR:   data_out_d = dataA | dataB;
                            OP_ADD: begin
                                data_out_d = sum;
                                carry_d    = sum_ext[WIDTH];
                                ovf_d      = add_ovf;
                            end
                            OP_SUB: begin
                                data_out_d = sum;
                                carry_d    = sum_ext[WIDTH];
                                ovf_d      = sub_ovf;
                            end
                            OP_SLT:  data_out_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sub_ovf};
                            OP_MFHI: data_out_d = hi_q;
                            OP_MFLO: data_out_d = lo_q;
                            default: data_out_d = '0;
                        endcase
                    end
                end
            end
            RUN: begin
                wh_d  = step_hi;
                wl_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    hi_d       = step_hi;
                    lo_d       = step_lo;
                    data_out_d = step_lo;
                    carry_d    = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        zero_d = (data_out_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            opnd_q     <= '0;
            wh_q       <= '0;
            wl_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            data_out_q <= '0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            opnd_q     <= opnd_d;
            wh_q       <= wh_d;
            wl_q       <= wl_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            data_out_q <= data_out_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dataOut  = data_out_q;
    assign CarryOut = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq

module tb_alu_seq;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_UNDEF = 4'b1111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataOut;
    logic        CarryOut;
    logic        Overflow;
    logic        Zero;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_cycles;
    int done_seen;

    alu_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Signal   (Signal),
        .dataA    (dataA),
        .dataB    (dataB),
        .dataOut  (dataOut),
        .CarryOut (CarryOut),
        .Overflow (Overflow),
        .Zero     (Zero),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; start stays high so callers can chain steps.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        Signal = op;
        dataA  = a;
        dataB  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Called right after a MULTU/DIVU accept edge. Waits (bounded) for done,
    // counting busy cycles; optionally pokes an ADD start in mid-run.
    task automatic run_long(input bit inject, output int n_lat, output int n_busy);
        start  = 1'b0;
        n_busy = busy ? 1 : 0;
        n_lat  = 0;
        while (!done && n_lat < 100) begin
            if (inject && n_lat == 10) begin
                start  = 1'b1;
                Signal = OP_ADD;
                dataA  = 32'd1;
                dataB  = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n_lat++;
            if (busy) n_busy++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        Signal = OP_AND;
        dataA  = '0;
        dataB  = '0;

        // Reset held two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_dataOut", dataOut, 32'h0);
        chk("rst_zero", {31'b0, Zero}, 32'd1);
        chk("rst_carry", {31'b0, CarryOut}, 32'd0);
        chk("rst_ovf", {31'b0, Overflow}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);

        step(OP_MFHI, 32'h0, 32'h0);
        start = 1'b0;
        chk("rst_mfhi", dataOut, 32'h0);
        chk("rst_mfhi_done", {31'b0, done}, 32'd1);

        // ADD signed overflow
        step(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        start = 1'b0;
        chk("add_ovf_res", dataOut, 32'h8000_0000);
        chk("add_ovf_v", {31'b0, Overflow}, 32'd1);
        chk("add_ovf_c", {31'b0, CarryOut}, 32'd0);
        chk("add_ovf_done", {31'b0, done}, 32'd1);
        idle_cycle();
        chk("add_done_pulse_end", {31'b0, done}, 32'd0);
        chk("add_hold", dataOut, 32'h8000_0000);

        // ADD unsigned carry out to zero
        step(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        start = 1'b0;
        chk("add_c_res", dataOut, 32'h0);
        chk("add_c_zero", {31'b0, Zero}, 32'd1);
        chk("add_c_c", {31'b0, CarryOut}, 32'd1);
        chk("add_c_v", {31'b0, Overflow}, 32'd0);

        // SUB
        step(OP_SUB, 32'd5, 32'd5);
        start = 1'b0;
        chk("sub_eq_res", dataOut, 32'h0);
        chk("sub_eq_zero", {31'b0, Zero}, 32'd1);
        chk("sub_eq_c", {31'b0, CarryOut}, 32'd1);
        step(OP_SUB, 32'd3, 32'd5);
        start = 1'b0;
        chk("sub_neg_res", dataOut, 32'hFFFF_FFFE);
        chk("sub_neg_c", {31'b0, CarryOut}, 32'd0);
        chk("sub_neg_v", {31'b0, Overflow}, 32'd0);
        chk("sub_neg_zero", {31'b0, Zero}, 32'd0);

        // AND / OR / undefined code
        step(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
        start = 1'b0;
        chk("and_res", dataOut, 32'h0000_F000);
        step(OP_OR, 32'h0000_F0F0, 32'h0000_FF00);
        start = 1'b0;
        chk("or_res", dataOut, 32'h0000_FFF0);
        step(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(OP_UNDEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b0;
        chk("undef_res", dataOut, 32'h0);
        chk("undef_c", {31'b0, CarryOut}, 32'd0);
        chk("undef_done", {31'b0, done}, 32'd1);

        // SLT back-to-back: three consecutive done pulses
        step(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("slt1_res", dataOut, 32'd1);
        chk("slt1_done", {31'b0, done}, 32'd1);
        step(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
        chk("slt2_res", dataOut, 32'd0);
        chk("slt2_done", {31'b0, done}, 32'd1);
        step(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
        start = 1'b0;
        chk("slt3_res", dataOut, 32'd1);
        chk("slt3_done", {31'b0, done}, 32'd1);
        chk("slt3_v", {31'b0, Overflow}, 32'd0);

        // MULTU max x max with an ignored ADD request mid-run
        step(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_busy_start", {31'b0, busy}, 32'd1);
        chk("mul_no_done_start", {31'b0, done}, 32'd0);
        run_long(1'b1, lat, busy_cycles);
        chk("mul_latency", lat, 32'd32);
        chk("mul_busy_cycles", busy_cycles, 32'd32);
        chk("mul_lo_out", dataOut, 32'h0000_0001);
        chk("mul_busy_end", {31'b0, busy}, 32'd0);
        idle_cycle();
        chk("mul_no_extra_done", {31'b0, done}, 32'd0);
        step(OP_MFHI, 32'h0, 32'h0);
        start = 1'b0;
        chk("mul_mfhi", dataOut, 32'hFFFF_FFFE);
        step(OP_MFLO, 32'h0, 32'h0);
        start = 1'b0;
        chk("mul_mflo", dataOut, 32'h0000_0001);

        // DIVU 100/7
        step(OP_DIVU, 32'd100, 32'd7);
        run_long(1'b0, lat, busy_cycles);
        chk("div_latency", lat, 32'd32);
        chk("div_lo_out", dataOut, 32'd14);
        step(OP_MFLO, 32'h0, 32'h0);
        start = 1'b0;
        chk("div_mflo", dataOut, 32'd14);
        step(OP_MFHI, 32'h0, 32'h0);
        start = 1'b0;
        chk("div_mfhi", dataOut, 32'd2);

        // DIVU by zero
        step(OP_DIVU, 32'h1234_5678, 32'h0);
        run_long(1'b0, lat, busy_cycles);
        chk("div0_latency", lat, 32'd32);
        chk("div0_busy_cycles", busy_cycles, 32'd32);
        chk("div0_lo_out", dataOut, 32'hFFFF_FFFF);
        step(OP_MFHI, 32'h0, 32'h0);
        start = 1'b0;
        chk("div0_mfhi", dataOut, 32'h1234_5678);

        // Reset during MULTU aborts it
        step(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_dataOut", dataOut, 32'h0);
        chk("abort_zero", {31'b0, Zero}, 32'd1);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 32'd0);
        step(OP_MFHI, 32'h0, 32'h0);
        start = 1'b0;
        chk("abort_mfhi", dataOut, 32'h0);
        step(OP_MFLO, 32'h0, 32'h0);
        start = 1'b0;
        chk("abort_mflo", dataOut, 32'h0);

        // Fresh MULTU after abort
        step(OP_MULTU, 32'd3, 32'd4);
        run_long(1'b0, lat, busy_cycles);
        chk("mul34_latency", lat, 32'd32);
        chk("mul34_lo_out", dataOut, 32'd12);
        step(OP_MFHI, 32'h0, 32'h0);
        start = 1'b0;
        chk("mul34_mfhi", dataOut, 32'h0);

        idle_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
